// File: rtl/ru_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states and requester identities.
package ru_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

endpackage

// File: rtl/ru_busy_timer.sv
// Saturating count of consecutive RAM stall cycles; flags the stall cycle that reaches the limit.
module ru_busy_timer #(
    parameter int TIMEOUT = 16,
    localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High during the stall cycle whose increment brings the count up to TIMEOUT.
    assign o_expired = i_en && (int'(r_count) >= TIMEOUT - 1);

endmodule

// File: rtl/ru_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between an instruction-fetch port and a data port.
module ru_mem_arbiter
    import ru_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wen,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_ack,
    output logic              d_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              i_err,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_busy
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    arb_req_t          r_winner;
    arb_req_t          r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_err;
    logic              r_d_err;

    logic              w_any;
    arb_req_t          w_pick;
    logic [ADDR_W-1:0] w_pick_addr;
    logic              w_aligned;
    logic              w_expired;
    logic              w_resp_load;
    arb_req_t          w_resp_port;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_resp_err;

    assign w_any = i_req || d_req;

    // On contention the port not served last wins; a lone request always wins.
    always_comb begin
        if (i_req && d_req) begin
            w_pick = (r_last == REQ_I) ? REQ_D : REQ_I;
        end else if (d_req) begin
            w_pick = REQ_D;
        end else begin
            w_pick = REQ_I;
        end
    end

    assign w_pick_addr = (w_pick == REQ_D) ? d_addr : i_addr;
    assign w_aligned   = (w_pick_addr[1:0] == 2'b00);

    ru_busy_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_busy_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     ((r_state == IDLE) && w_any && w_aligned),
        .i_en      ((r_state == ACCESS) && ram_busy),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_resp_load  = 1'b0;
        w_resp_port  = r_winner;
        w_resp_data  = '0;
        w_resp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    if (w_aligned) begin
                        w_state_next = ACCESS;
                    end else begin
                        w_state_next = RESP;
                        w_resp_load  = 1'b1;
                        w_resp_port  = w_pick;
                        w_resp_err   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (!ram_busy) begin
                    w_state_next = RESP;
                    w_resp_load  = 1'b1;
                    w_resp_data  = ram_rdata;
                end else if (w_expired) begin
                    w_state_next = RESP;
                    w_resp_load  = 1'b1;
                    w_resp_err   = 1'b1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_winner  <= REQ_I;
            r_last    <= REQ_I;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wen     <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_err   <= 1'b0;
            r_d_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && w_any) begin
                r_winner <= w_pick;
                if (w_aligned) begin
                    r_addr  <= w_pick_addr;
                    r_wdata <= (w_pick == REQ_D) ? d_wdata : '0;
                    r_wen   <= (w_pick == REQ_D) && d_wen;
                end else begin
                    r_wen   <= 1'b0;
                end
            end
            if (r_state == RESP) begin
                r_last <= r_winner;
            end
            if (w_resp_load) begin
                if (w_resp_port == REQ_D) begin
                    r_d_rdata <= w_resp_data;
                    r_d_err   <= w_resp_err;
                end else begin
                    r_i_rdata <= w_resp_data;
                    r_i_err   <= w_resp_err;
                end
            end
        end
    end

    // Command outputs are only meaningful in ACCESS; the write strobe is gated by state so reset kills it at once.
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign ram_wen   = (r_state == ACCESS) && r_wen;

    assign i_ack   = (r_state == RESP) && (r_winner == REQ_I);
    assign d_ack   = (r_state == RESP) && (r_winner == REQ_D);
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign i_err   = r_i_err;
    assign d_err   = r_d_err;

endmodule

// File: tb/tb_ru_mem_arbiter.sv
// Directed self-checking bench for ru_mem_arbiter: latency, round-robin, writes, misalignment, stalls, reset abort.
module tb_ru_mem_arbiter;
    import ru_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wen;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack, i_err, d_err;
    logic [DW-1:0] i_rdata, d_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wen;
    logic [DW-1:0] ram_rdata;
    logic          ram_busy;

    int tests    = 0;
    int fails    = 0;
    int both_cnt = 0;

    // Transaction results
    int            steps, wen_cnt;
    logic          gi, gd;
    logic [AW-1:0] wen_addr;
    logic [DW-1:0] wen_data;

    ru_mem_arbiter #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .d_req     (d_req),
        .i_addr    (i_addr),
        .d_addr    (d_addr),
        .d_wen     (d_wen),
        .d_wdata   (d_wdata),
        .i_ack     (i_ack),
        .d_ack     (d_ack),
        .i_rdata   (i_rdata),
        .d_rdata   (d_rdata),
        .i_err     (i_err),
        .d_err     (d_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .ram_rdata (ram_rdata),
        .ram_busy  (ram_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (i_ack && d_ack) both_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps clock edges until an ack appears (or maxc edges pass); rel>0 drops ram_busy at that step.
    task automatic run_txn(input int maxc, input int rel,
                           output int n, output logic a_i, output logic a_d,
                           output int wc, output logic [AW-1:0] wa, output logic [DW-1:0] wd);
        n = 0; a_i = 1'b0; a_d = 1'b0; wc = 0; wa = '0; wd = '0;
        while (n < maxc) begin
            step();
            n++;
            if (rel != 0 && n == rel) ram_busy = 1'b0;
            if (ram_wen) begin
                wc++;
                wa = ram_addr;
                wd = ram_wdata;
            end
            if (i_ack || d_ack) begin
                a_i = i_ack;
                a_d = d_ack;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        ram_rdata = '0; ram_busy = 1'b0;

        // Reset state
        step(); step();
        chk("rst_i_ack", 64'(i_ack), 64'd0);
        chk("rst_d_ack", 64'(d_ack), 64'd0);
        chk("rst_ram_wen", 64'(ram_wen), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_i_rdata", 64'(i_rdata), 64'd0);
        chk("rst_state", 64'(dut.r_state), 64'(IDLE));
        rst = 1'b0;
        step();

        // Single fetch: request cycle, ACCESS, ack in the third cycle (two edges)
        ram_rdata = 32'hDEADBEEF; i_addr = 32'h10; i_req = 1'b1;
        run_txn(40, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("fetch_edges", 64'(steps), 64'd2);
        chk("fetch_i_ack", 64'(gi), 64'd1);
        chk("fetch_rdata", 64'(i_rdata), 64'hDEADBEEF);
        chk("fetch_err", 64'(i_err), 64'd0);
        i_req = 1'b0;
        step();

        // Simultaneous pair from reset: data first, fetch three edges later, then data again
        rst = 1'b1; step(); rst = 1'b0; step();
        ram_rdata = 32'h0000AAAA; i_addr = 32'h20; d_addr = 32'h24; d_wen = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        run_txn(40, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("pair1_edges", 64'(steps), 64'd2);
        chk("pair1_d_first", 64'({gi, gd}), 64'b01);
        chk("pair1_d_rdata", 64'(d_rdata), 64'h0000AAAA);
        d_req = 1'b0;
        ram_rdata = 32'h0000BBBB;
        run_txn(40, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("pair2_gap", 64'(steps), 64'd3);
        chk("pair2_i_next", 64'({gi, gd}), 64'b10);
        chk("pair2_i_rdata", 64'(i_rdata), 64'h0000BBBB);
        i_req = 1'b0;
        step();
        i_req = 1'b1; d_req = 1'b1;
        run_txn(40, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("pair3_d_again", 64'({gi, gd}), 64'b01);
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Data write: one write strobe with latched command; ack carries pre-write contents
        ram_rdata = 32'hCAFE0001;
        d_addr = 32'h8; d_wdata = 32'h1234; d_wen = 1'b1; d_req = 1'b1;
        run_txn(40, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("wr_edges", 64'(steps), 64'd2);
        chk("wr_d_ack", 64'({gi, gd}), 64'b01);
        chk("wr_wen_cycles", 64'(wen_cnt), 64'd1);
        chk("wr_ram_addr", 64'(wen_addr), 64'h8);
        chk("wr_ram_wdata", 64'(wen_data), 64'h1234);
        chk("wr_old_rdata", 64'(d_rdata), 64'hCAFE0001);
        chk("wr_err", 64'(d_err), 64'd0);
        d_req = 1'b0;
        step();

        // Misaligned write: straight to RESP, err set, no strobe
        d_addr = 32'h6; d_wdata = 32'h5555; d_wen = 1'b1; d_req = 1'b1;
        run_txn(40, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("mis_edges", 64'(steps), 64'd1);
        chk("mis_d_ack", 64'({gi, gd}), 64'b01);
        chk("mis_err", 64'(d_err), 64'd1);
        chk("mis_rdata", 64'(d_rdata), 64'd0);
        chk("mis_wen_cycles", 64'(wen_cnt), 64'd0);
        d_req = 1'b0; d_wen = 1'b0;
        step();

        // Stall held: 16 busy ACCESS cycles then abort with err
        ram_rdata = 32'h00000055; ram_busy = 1'b1;
        i_addr = 32'h40; i_req = 1'b1;
        run_txn(60, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("to_edges", 64'(steps), 64'd17);
        chk("to_i_ack", 64'({gi, gd}), 64'b10);
        chk("to_err", 64'(i_err), 64'd1);
        chk("to_rdata", 64'(i_rdata), 64'd0);
        chk("to_wen_after", 64'(ram_wen), 64'd0);
        i_req = 1'b0; ram_busy = 1'b0;
        step();

        // Stall released after 5 busy cycles: normal completion
        ram_rdata = 32'h00000077; ram_busy = 1'b1;
        d_addr = 32'h4C; d_wen = 1'b0; d_req = 1'b1;
        run_txn(60, 6, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("rel_edges", 64'(steps), 64'd7);
        chk("rel_d_ack", 64'({gi, gd}), 64'b01);
        chk("rel_err", 64'(d_err), 64'd0);
        chk("rel_rdata", 64'(d_rdata), 64'h77);
        d_req = 1'b0; ram_busy = 1'b0;
        step();

        // Reset during a write ACCESS: strobe drops at once, FSM idle, no ack later
        d_addr = 32'h10; d_wdata = 32'hAA; d_wen = 1'b1; d_req = 1'b1;
        step();
        chk("rs_wen_in_access", 64'(ram_wen), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_wen_dropped", 64'(ram_wen), 64'd0);
        chk("rs_state_idle", 64'(dut.r_state), 64'(IDLE));
        d_req = 1'b0; d_wen = 1'b0;
        step();
        rst = 1'b0;
        run_txn(5, 0, steps, gi, gd, wen_cnt, wen_addr, wen_data);
        chk("rs_no_ack", 64'({gi, gd}), 64'b00);
        chk("rs_no_wen", 64'(wen_cnt), 64'd0);
        chk("rs_d_rdata", 64'(d_rdata), 64'd0);

        chk("acks_exclusive", 64'(both_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
